seq_detector_param: RTL

Parametrised serial bit-pattern detector. It samples a qualified serial input stream and compares it against a runtime-loadable pattern of programmable length (1..PAT_W bits). For each match it emits a one-cycle pulse and increments a saturating match counter. Overlapping or non-overlapping detection is selectable at runtime. It sits after serial receivers and line decoders as a generalised replacement for fixed-pattern detectors.

---
 rtl/seq_detector_param.sv | 118 +++++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial pattern detector with a
// registered match pulse, selectable overlap and a saturating match counter.
module seq_detector_param #(
    parameter int unsigned          PAT_W    = 4,
    parameter logic [PAT_W-1:0]     PAT_INIT = PAT_W'(4'b1011),
    parameter int unsigned          COUNT_W  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          x,
    input  logic                          x_valid,
    input  logic                          load,
    input  logic [PAT_W-1:0]              pattern,
    input  logic [$clog2(PAT_W+1)-1:0]    pat_len,
    input  logic                          overlap,
    output logic                          y,
    output logic [COUNT_W-1:0]            match_count
);

    localparam int unsigned LEN_W = $clog2(PAT_W + 1);
    localparam int unsigned CMP_W = LEN_W + 1;

    localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(PAT_W);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    // Registered state
    logic [PAT_W-1:0]   pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic [PAT_W-1:0]   history_q;
    logic [LEN_W-1:0]   fill_q;
    logic [COUNT_W-1:0] count_q;
    logic               y_q;

    // Next-state values
    logic [PAT_W-1:0]   pattern_d;
    logic [LEN_W-1:0]   len_d;
    logic [PAT_W-1:0]   history_d;
    logic [LEN_W-1:0]   fill_d;
    logic [COUNT_W-1:0] count_d;
    logic               y_d;

    // Match datapath intermediates
    logic [PAT_W-1:0]   hist_shift;
    logic [PAT_W-1:0]   len_mask;
    logic [CMP_W-1:0]   fill_inc;
    logic [CMP_W-1:0]   len_ext;
    logic               bits_eq;
    logic               enough_bits;
    logic               hit;
    logic [LEN_W-1:0]   len_load;

    // Next-state logic: load dominates, then valid-bit shift/compare, else hold
    always_comb begin
        pattern_d   = pattern_q;
        len_d       = len_q;
        history_d   = history_q;
        fill_d      = fill_q;
        count_d     = count_q;
        y_d         = 1'b0;

        hist_shift  = {history_q[PAT_W-2:0], x};
        for (int i = 0; i < int'(PAT_W); i++) begin
            len_mask[i] = (32'(i) < 32'(len_q));
        end
        fill_inc    = CMP_W'(fill_q) + CMP_W'(1);
        len_ext     = CMP_W'(len_q);
        bits_eq     = ((hist_shift ^ pattern_q) & len_mask) == '0;
        enough_bits = (fill_inc >= len_ext);
        hit         = bits_eq && enough_bits;

        // Zero or out-of-range lengths fall back to the full pattern width
        if ((pat_len == '0) || (pat_len > LEN_MAX)) begin
            len_load = LEN_MAX;
        end else begin
            len_load = pat_len;
        end

        if (load) begin
            pattern_d = pattern;
            len_d     = len_load;
            history_d = '0;
            fill_d    = '0;
            count_d   = '0;
        end else if (x_valid) begin
            history_d = hist_shift;
            if (hit) begin
                y_d     = 1'b1;
                count_d = (count_q == CNT_MAX) ? CNT_MAX : count_q + COUNT_W'(1);
                fill_d  = overlap ? len_q : '0;
            end else begin
                fill_d  = (fill_inc > len_ext) ? len_q : fill_inc[LEN_W-1:0];
            end
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern_q <= PAT_INIT;
            len_q     <= LEN_MAX;
            history_q <= '0;
            fill_q    <= '0;
            count_q   <= '0;
            y_q       <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            history_q <= history_d;
            fill_q    <= fill_d;
            count_q   <= count_d;
            y_q       <= y_d;
        end
    end

    assign y           = y_q;
    assign match_count = count_q;

endmodule
